// File: rtl/elbeth_pkg.sv
// Shared ELBETH arbitration constants and elaboration-time helpers.
package elbeth_pkg;

    localparam int ELBETH_ARB_FIXED = 0;
    localparam int ELBETH_ARB_RR    = 1;

    // Index width for n entries; never below 1 so a 1-bit port always exists.
    function automatic int elbeth_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/elbeth_rr_arbiter.sv
// One-hot arbiter: fixed priority (lowest index) or round robin from a
// rotating pointer that moves past the last granted channel.
module elbeth_rr_arbiter
    import elbeth_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = ELBETH_ARB_RR,
    localparam int CH_W = elbeth_clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            found;
    int              idx;

    // Walk N_CH candidates starting at the pointer (or at 0 in fixed mode);
    // the first requester hit wins, which also handles the wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (MODE == ELBETH_ARB_RR) ? k + int'(ptr_q) : k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == ELBETH_ARB_RR && advance) begin
            ptr_d = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/elbeth_mux_n_to_1_rr.sv
// N-channel valid/ready selector onto one registered output beat;
// 1-cycle latency, full throughput while downstream keeps accepting.
module elbeth_mux_n_to_1_rr
    import elbeth_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_CH   = 4,
    parameter int MODE   = ELBETH_ARB_RR,
    localparam int CH_W  = elbeth_clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic              load;
    logic              xfer;
    logic [N_CH-1:0]   grant;
    logic [CH_W-1:0]   grant_idx;
    logic [DATA_W-1:0] sel_data;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    // The output slot can take a beat when it is empty or draining this cycle.
    assign load     = ~out_valid_q | out_ready;
    assign in_ready = grant & {N_CH{load & ~rst}};
    assign xfer     = |in_ready;

    elbeth_rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot AND-OR select keeps the mux free of a wide indexed shifter.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) sel_data = sel_data | in_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
